adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter ADD_LAT, default 2, SHALL set the number of cycles the external 16-bit ripple-carry adder needs to settle; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous, active-high.
REQ-004 reqN_valid  input  1 (N=0,1)  SHALL indicate requester N presents an operation.
REQ-005 reqN_ready  output  1  SHALL indicate requester N's operation is accepted this cycle.
REQ-006 reqN_a, reqN_b  input  8 each  SHALL be signed two's-complement operands.
REQ-007 reqN_sub  input  1  SHALL select a-b when 1 and a+b when 0.
REQ-008 add_a, add_b  output  16 each  SHALL drive the shared adder's operands.
REQ-009 add_cin  output  1  SHALL drive the shared adder's carry-in.
REQ-010 add_sum  input  16  SHALL be the shared adder's result.
REQ-011 rsp_valid  output  1  SHALL flag a valid response.
REQ-012 rsp_ready  input  1  SHALL indicate the consumer takes the response.
REQ-013 rsp_id  output  1  SHALL identify the requester the response belongs to.
REQ-014 rsp_sum  output  16  SHALL carry the signed result.
REQ-015 rsp_ovf8  output  1  SHALL flag that rsp_sum lies outside -128..127.

Function
REQ-016 FSM states SHALL be IDLE, BUSY, RESP.
REQ-017 In IDLE, at most one reqN_ready SHALL be high, only for the arbitration winner among requesters with valid high; transfer occurs on valid&&ready, and the state SHALL move to BUSY.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-019 At accept, operands SHALL be latched and sign-extended to 16 bits (bits 15:8 = bit 7).
REQ-020 In BUSY, add_a = sext(a); for add, add_b = sext(b) and add_cin=0; for sub, add_b = ~sext(b) and add_cin=1; the values SHALL be held stable for the whole of BUSY.
REQ-021 BUSY SHALL last exactly ADD_LAT cycles (down-counter); add_sum SHALL be captured on the last BUSY cycle, and the state SHALL move to RESP.
REQ-022 With accept in cycle T, rsp_valid SHALL rise in cycle T+ADD_LAT+1.
REQ-023 In RESP, rsp_valid, rsp_id, rsp_sum and rsp_ovf8 SHALL hold stable until rsp_valid&&rsp_ready, then the state SHALL return to IDLE.
REQ-024 No reqN_ready SHALL assert in BUSY or RESP; the earliest next accept SHALL be the cycle after the response handshake.
REQ-025 rsp_ovf8 SHALL equal 1 when rsp_sum[15:7] is not all-equal.
REQ-026 Outside BUSY, add_a, add_b and add_cin SHALL be 0.
REQ-027 A 16-bit result of two sign-extended 8-bit operands cannot overflow; no 16-bit overflow flag exists.

Reset
REQ-028 While rst is high at a clock edge, the state SHALL go to IDLE, the counter to 0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_ovf8=0, reqN_ready=0 and add_* =0.
REQ-029 Reset SHALL set the last-grant pointer to 1, so req0 wins the first contested arbitration.
REQ-030 Reset mid-BUSY or mid-RESP SHALL drop the transaction with no response issued.

Verification
REQ-031 ADD_LAT=2; req0 a=8'h7F, b=8'h01, sub=0 accepted at T -> rsp_valid at T+3, rsp_id=0, rsp_sum=16'h0080, rsp_ovf8=1.
REQ-032 req1 a=8'h80, b=8'h01, sub=1 -> add_b=16'hFFFE, add_cin=1 during BUSY; rsp_sum=16'hFF7F, rsp_ovf8=1, rsp_id=1.
REQ-033 req0 a=8'hFB (-5), b=8'h03, add -> rsp_sum=16'hFFFE, rsp_ovf8=0.
REQ-034 Both valid continuously from reset, rsp_ready=1 -> grant order 0,1,0,1; each accept one cycle after the prior response handshake.
REQ-035 rsp_ready low for 5 cycles in RESP -> response fields stable, both reqN_ready=0, then handshake and return to IDLE.
REQ-036 rst pulsed in the second BUSY cycle -> no rsp_valid ever for that operation; all outputs 0; with both valid next, req0 is granted.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// Bundle of the two requester ports, the shared-adder port and the response port
// of adder_arbiter. The arbiter uses the slave view; the environment uses the master view.
interface adder_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req0_sub;

  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        req1_sub;

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_ovf8;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  add_sum, rsp_ready,
    output req0_ready, req1_ready,
    output add_a, add_b, add_cin,
    output rsp_valid, rsp_id, rsp_sum, rsp_ovf8
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output add_sum, rsp_ready,
    input  req0_ready, req1_ready,
    input  add_a, add_b, add_cin,
    input  rsp_valid, rsp_id, rsp_sum, rsp_ovf8
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external multi-cycle 16-bit adder between two
// requesters of signed 8-bit add/sub operations; one operation in flight at a time.
module adder_arbiter #(
  parameter int unsigned ADD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  adder_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT = 4'(ADD_LAT);

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  // Result fits 8 bits signed only when bits 15:7 are all copies of the sign.
  function automatic logic ovf8(input logic [15:0] s);
    return !((s[15:7] == 9'h1FF) || (s[15:7] == 9'h000));
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [15:0] add_a_q, add_a_d;
  logic [15:0] add_b_q, add_b_d;
  logic        add_cin_q, add_cin_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_sum_q, rsp_sum_d;
  logic        rsp_ovf8_q, rsp_ovf8_d;

  logic        grant0_s, grant1_s, accept_s;
  logic [7:0]  op_a_s, op_b_s;
  logic        op_sub_s;

  // Arbitration: only in IDLE and out of reset; contested requests go to the one not granted last.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0_s = last_q;
        grant1_s = !last_q;
      end else if (bus.req0_valid) begin
        grant0_s = 1'b1;
      end else if (bus.req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign accept_s = grant0_s || grant1_s;
  assign op_a_s   = grant1_s ? bus.req1_a   : bus.req0_a;
  assign op_b_s   = grant1_s ? bus.req1_b   : bus.req0_b;
  assign op_sub_s = grant1_s ? bus.req1_sub : bus.req0_sub;

  // Next-state and datapath: latch operands at accept, count BUSY down, capture at the last BUSY cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_ovf8_d  = rsp_ovf8_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d   = BUSY;
          cnt_d     = LAT;
          last_d    = grant1_s;
          rsp_id_d  = grant1_s;
          add_a_d   = sext8(op_a_s);
          add_b_d   = op_sub_s ? ~sext8(op_b_s) : sext8(op_b_s);
          add_cin_d = op_sub_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d     = RESP;
          cnt_d       = 4'd0;
          add_a_d     = 16'h0000;
          add_b_d     = 16'h0000;
          add_cin_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_sum_d   = bus.add_sum;
          rsp_ovf8_d  = ovf8(bus.add_sum);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_id_d    = 1'b0;
          rsp_sum_d   = 16'h0000;
          rsp_ovf8_d  = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 4'd0;
        add_a_d     = 16'h0000;
        add_b_d     = 16'h0000;
        add_cin_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = 1'b0;
        rsp_sum_d   = 16'h0000;
        rsp_ovf8_d  = 1'b0;
      end
    endcase
  end

  // State register; reset drops any transaction in flight and favours req0 next.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      add_a_q     <= 16'h0000;
      add_b_q     <= 16'h0000;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= 16'h0000;
      rsp_ovf8_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_ovf8_q  <= rsp_ovf8_d;
    end
  end

  assign bus.req0_ready = grant0_s;
  assign bus.req1_ready = grant1_s;
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.add_cin    = add_cin_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_sum    = rsp_sum_q;
  assign bus.rsp_ovf8   = rsp_ovf8_q;

endmodule
